writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: merges ALU and load results into one register-file write port,
// counts retired instructions and stops accepting work after a halt.
module writeback_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_halt,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [63:0]           retire_count,
  output logic                  halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                  state_q, state_d;
  logic                    write_enable_q, write_enable_d;
  logic [ADDR_WIDTH-1:0]   write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
  logic [63:0]             retire_count_q, retire_count_d;
  logic [DATA_WIDTH-1:0]   load_value;
  logic                    mem_accept;
  logic                    alu_accept;

  // Loads take priority; the ALU source is back-pressured while a load is valid.
  assign mem_ready  = (state_q == RUN);
  assign alu_ready  = (state_q == RUN) && !mem_valid;
  assign mem_accept = mem_valid && mem_ready;
  assign alu_accept = alu_valid && alu_ready;

  always_comb begin
    load_value = mem_data;
    case (mem_size)
      2'd0: load_value = {{(DATA_WIDTH-8){~mem_unsigned & mem_data[7]}}, mem_data[7:0]};
      2'd1: load_value = {{(DATA_WIDTH-16){~mem_unsigned & mem_data[15]}}, mem_data[15:0]};
      2'd2: load_value = {{(DATA_WIDTH-32){~mem_unsigned & mem_data[31]}}, mem_data[31:0]};
      default: load_value = mem_data;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    write_enable_d = 1'b0;
    write_addr_d   = write_addr_q;
    write_data_d   = write_data_q;
    retire_count_d = retire_count_q;
    if (mem_accept) begin
      write_enable_d = (mem_rd != '0);
      write_addr_d   = mem_rd;
      write_data_d   = load_value;
      retire_count_d = retire_count_q + 64'd1;
    end else if (alu_accept) begin
      write_enable_d = (alu_rd != '0);
      write_addr_d   = alu_rd;
      write_data_d   = alu_result;
      retire_count_d = retire_count_q + 64'd1;
      if (alu_halt) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign retire_count = retire_count_q;
  assign halted       = (state_q == HALTED);

endmodule
